l1_dcache_req_sequencer: RTL and testbench

Control FSM that sequences one load or store at a time through the L1 data-cache adapter. It accepts a one-cycle load/store pulse from the core pipeline and, when translation is enabled, requests a DTLB translation. It then tells the adapter when to freeze the physical address, asserts the adapter's memory-request valid in the cycle the dcache accepts it, and waits for the dcache response. Completion, replay and error are reported back to the core.

---
 rtl/l1_dcache_req_sequencer.sv | 148 ++++++++++++++
 tb/tb_l1_dcache_req_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_dcache_req_sequencer.sv
// Sequences one load/store at a time through DTLB translation and the L1 dcache adapter.
// Optional watchdog on TRANS/WAIT_RESP is compiled in with `define L1_DCACHE_SEQ_TIMEOUT_EN.
module l1_dcache_req_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             is_load_i,
  input  logic             is_store_i,
  input  logic             trns_ena_i,
  input  logic             dtlb_hit_i,
  input  logic             dcache_req_ready_i,
  input  logic             dcache_resp_valid_i,
  input  logic             dcache_nack_i,
  output logic             st_translation_req_o,
  output logic             str_rdy_o,
  output logic             mem_req_valid_o,
  output logic             busy_o,
  output logic             op_is_store_o,
  output logic             done_o,
  output logic             replay_o,
  output logic             timeout_o,
  output logic             protocol_err_o,
  output logic [CNT_W-1:0] replay_cnt_o,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRANS     = 2'd1,
    REQ       = 2'd2,
    WAIT_RESP = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   req_pulse;
  logic   done_nxt;
  logic   replay_nxt;
  logic   perr_nxt;

  assign req_pulse   = is_load_i | is_store_i;
  assign dbg_state_o = state;

  // Handshake: the adapter drops its op flags on any valid, so valid is only
  // raised in a REQ cycle where the dcache is ready; that cycle is the transfer.
  assign mem_req_valid_o = (state == REQ) & dcache_req_ready_i;

`ifdef L1_DCACHE_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             wd_expired;
  logic             timeout_nxt;

  assign wd_expired = ((state == TRANS) || (state == WAIT_RESP)) && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else if (state_nxt != state) begin
      wd_cnt <= '0;
    end else if ((state == TRANS) || (state == WAIT_RESP)) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_o          = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    done_nxt   = 1'b0;
    replay_nxt = 1'b0;
`ifdef L1_DCACHE_SEQ_TIMEOUT_EN
    timeout_nxt = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (req_pulse) state_nxt = trns_ena_i ? TRANS : REQ;
      end
      TRANS: begin
        if (dtlb_hit_i) state_nxt = REQ;
`ifdef L1_DCACHE_SEQ_TIMEOUT_EN
        else if (wd_expired) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
        end
`endif
      end
      REQ: begin
        if (dcache_req_ready_i) state_nxt = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (dcache_nack_i) begin
          state_nxt  = IDLE;
          replay_nxt = 1'b1;
        end else if (dcache_resp_valid_i) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
`ifdef L1_DCACHE_SEQ_TIMEOUT_EN
        else if (wd_expired) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
    // Simultaneous load+store in IDLE is taken as a store but flagged; any pulse while busy is dropped.
    perr_nxt = (state == IDLE) ? (is_load_i & is_store_i) : req_pulse;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      st_translation_req_o <= 1'b0;
      str_rdy_o            <= 1'b0;
      busy_o               <= 1'b0;
      op_is_store_o        <= 1'b0;
      done_o               <= 1'b0;
      replay_o             <= 1'b0;
      protocol_err_o       <= 1'b0;
      replay_cnt_o         <= '0;
`ifdef L1_DCACHE_SEQ_TIMEOUT_EN
      timeout_o            <= 1'b0;
`endif
    end else begin
      state                <= state_nxt;
      st_translation_req_o <= (state_nxt == TRANS);
      str_rdy_o            <= (state_nxt == REQ) || (state_nxt == WAIT_RESP);
      busy_o               <= (state_nxt != IDLE);
      done_o               <= done_nxt;
      replay_o             <= replay_nxt;
      protocol_err_o       <= perr_nxt;
`ifdef L1_DCACHE_SEQ_TIMEOUT_EN
      timeout_o            <= timeout_nxt;
`endif
      if ((state == IDLE) && req_pulse) op_is_store_o <= is_store_i;
      if (replay_nxt && (replay_cnt_o != '1)) replay_cnt_o <= replay_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_l1_dcache_req_sequencer.sv
// Bench for l1_dcache_req_sequencer: directed vector table, hand sequences and a
// randomized run against a transaction-level reference model.
module tb_l1_dcache_req_sequencer;

  localparam int CNT_W = 8;
`ifdef L1_DCACHE_SEQ_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 256;
`endif
  localparam int NV = 22;

  typedef struct packed {
    logic ld, st, trns, hit, rdy, resp, nack;
  } in_t;

  // o bits: {st_translation_req, str_rdy, mem_req_valid, busy, op_is_store, done, replay, protocol_err}
  typedef struct {
    in_t        i;
    logic [7:0] o;
    logic [7:0] c;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             is_load_i, is_store_i, trns_ena_i, dtlb_hit_i;
  logic             dcache_req_ready_i, dcache_resp_valid_i, dcache_nack_i;
  logic             st_translation_req_o, str_rdy_o, mem_req_valid_o, busy_o;
  logic             op_is_store_o, done_o, replay_o, timeout_o, protocol_err_o;
  logic [CNT_W-1:0] replay_cnt_o;
  logic [1:0]       dbg_state_o;

  int n_tests = 0;
  int n_fail  = 0;
  int seen_done = 0;
  int seen_rep  = 0;

  // Reference model: one outstanding transaction and the phase it is in.
  bit m_active, m_xlate, m_sent, m_op;
  bit m_done, m_rep, m_perr, m_to;
  int m_nacks, m_wait;

  vec_t tab[NV];

  l1_dcache_req_sequencer #(.TIMEOUT_CYCLES(TB_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .is_load_i           (is_load_i),
    .is_store_i          (is_store_i),
    .trns_ena_i          (trns_ena_i),
    .dtlb_hit_i          (dtlb_hit_i),
    .dcache_req_ready_i  (dcache_req_ready_i),
    .dcache_resp_valid_i (dcache_resp_valid_i),
    .dcache_nack_i       (dcache_nack_i),
    .st_translation_req_o(st_translation_req_o),
    .str_rdy_o           (str_rdy_o),
    .mem_req_valid_o     (mem_req_valid_o),
    .busy_o              (busy_o),
    .op_is_store_o       (op_is_store_o),
    .done_o              (done_o),
    .replay_o            (replay_o),
    .timeout_o           (timeout_o),
    .protocol_err_o      (protocol_err_o),
    .replay_cnt_o        (replay_cnt_o),
    .dbg_state_o         (dbg_state_o)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench still running at t=%0t, expected to finish", $time);
    $fatal(1, "bench time limit reached");
  end

  function automatic vec_t v(input logic [6:0] i, input logic [7:0] o, input logic [7:0] c);
    vec_t r;
    r.i = in_t'(i);
    r.o = o;
    r.c = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, want 'h%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input in_t x);
    is_load_i           = x.ld;
    is_store_i          = x.st;
    trns_ena_i          = x.trns;
    dtlb_hit_i          = x.hit;
    dcache_req_ready_i  = x.rdy;
    dcache_resp_valid_i = x.resp;
    dcache_nack_i       = x.nack;
  endtask

  task automatic model_reset();
    m_active = 0; m_xlate = 0; m_sent = 0; m_op = 0;
    m_done = 0; m_rep = 0; m_perr = 0; m_to = 0;
    m_nacks = 0; m_wait = 0;
  endtask

  task automatic model_update(input in_t x);
    bit req;
    bit idle_wait;
    req = x.ld | x.st;
    idle_wait = 0;
    m_done = 0; m_rep = 0; m_perr = 0; m_to = 0;
    if (!m_active) begin
      if (req) begin
        m_active = 1; m_op = x.st; m_xlate = x.trns; m_sent = 0;
        m_perr = x.ld & x.st;
        m_wait = 0;
      end
    end else begin
      m_perr = req;
      if (m_xlate) begin
        if (x.hit) m_xlate = 0;
        else idle_wait = 1;
      end else if (!m_sent) begin
        if (x.rdy) begin m_sent = 1; m_wait = 0; end
      end else if (x.nack) begin
        m_rep = 1; m_nacks++; m_active = 0;
      end else if (x.resp) begin
        m_done = 1; m_active = 0;
      end else begin
        idle_wait = 1;
      end
      if (idle_wait) begin
`ifdef L1_DCACHE_SEQ_TIMEOUT_EN
        if (m_wait == TB_TIMEOUT - 1) begin
          m_to = 1; m_active = 0;
        end else
`endif
        m_wait++;
      end
    end
  endtask

  task automatic check_model(input in_t x);
    chk("busy", busy_o, m_active);
    chk("st_translation_req", st_translation_req_o, m_active && m_xlate);
    chk("str_rdy", str_rdy_o, m_active && !m_xlate);
    chk("mem_req_valid", mem_req_valid_o, m_active && !m_xlate && !m_sent && x.rdy);
    chk("op_is_store", op_is_store_o, m_op);
    chk("done", done_o, m_done);
    chk("replay", replay_o, m_rep);
    chk("protocol_err", protocol_err_o, m_perr);
    chk("timeout", timeout_o, m_to);
    chk("replay_cnt", replay_cnt_o, (m_nacks > 255) ? 255 : m_nacks);
    seen_done += done_o;
    seen_rep  += replay_o;
  endtask

  // Driver: inputs at posedge+1, check at negedge, model steps on the edge.
  task automatic tick(input in_t x);
    drive(x);
    @(negedge clk);
    check_model(x);
    @(posedge clk);
    model_update(x);
    #1;
  endtask

  initial begin
    in_t x;
    int  trans_cycles;
    bit  to_seen;

    tab[0]  = v(7'b0110100, 8'b00000000, 8'd0);  // translated store request
    tab[1]  = v(7'b0000100, 8'b10011000, 8'd0);
    tab[2]  = v(7'b0000100, 8'b10011000, 8'd0);
    tab[3]  = v(7'b0001100, 8'b10011000, 8'd0);  // dtlb hit
    tab[4]  = v(7'b0000100, 8'b01111000, 8'd0);  // REQ with ready
    tab[5]  = v(7'b0100100, 8'b01011000, 8'd0);  // store while busy
    tab[6]  = v(7'b0000110, 8'b01011001, 8'd0);  // response
    tab[7]  = v(7'b0000000, 8'b00001100, 8'd0);  // done
    tab[8]  = v(7'b0000000, 8'b00001000, 8'd0);
    tab[9]  = v(7'b1000000, 8'b00001000, 8'd0);  // bypass load
    tab[10] = v(7'b0000000, 8'b01010000, 8'd0);
    tab[11] = v(7'b0000010, 8'b01010000, 8'd0);  // resp outside WAIT_RESP ignored
    tab[12] = v(7'b0000100, 8'b01110000, 8'd0);
    tab[13] = v(7'b0000000, 8'b01010000, 8'd0);
    tab[14] = v(7'b0000010, 8'b01010000, 8'd0);
    tab[15] = v(7'b0000000, 8'b00000100, 8'd0);
    tab[16] = v(7'b1100000, 8'b00000000, 8'd0);  // load+store together
    tab[17] = v(7'b0000000, 8'b01011001, 8'd0);
    tab[18] = v(7'b0001100, 8'b01111000, 8'd0);  // hit outside TRANS ignored
    tab[19] = v(7'b0000011, 8'b01011000, 8'd0);  // resp+nack together
    tab[20] = v(7'b0000000, 8'b00001010, 8'd1);
    tab[21] = v(7'b0000000, 8'b00001000, 8'd1);

    // Reset
    rst = 1'b0;
    drive(in_t'(7'b0));
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_busy", busy_o, 0);
    chk("reset_st_translation_req", st_translation_req_o, 0);
    chk("reset_str_rdy", str_rdy_o, 0);
    chk("reset_mem_req_valid", mem_req_valid_o, 0);
    chk("reset_op_is_store", op_is_store_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_replay", replay_o, 0);
    chk("reset_protocol_err", protocol_err_o, 0);
    chk("reset_timeout", timeout_o, 0);
    chk("reset_replay_cnt", replay_cnt_o, 0);
    chk("reset_dbg_state", dbg_state_o, 0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector table
    for (int k = 0; k < NV; k++) begin
      drive(tab[k].i);
      @(negedge clk);
      chk($sformatf("vec%0d_outs", k),
          {st_translation_req_o, str_rdy_o, mem_req_valid_o, busy_o,
           op_is_store_o, done_o, replay_o, protocol_err_o}, tab[k].o);
      chk($sformatf("vec%0d_replay_cnt", k), replay_cnt_o, tab[k].c);
      @(posedge clk);
      model_update(tab[k].i);
      #1;
    end

    // 300 nacked requests
    seen_done = 0;
    seen_rep  = 0;
    for (int n = 0; n < 300; n++) begin
      tick(in_t'(7'b1000100));
      tick(in_t'(7'b0000100));
      tick(in_t'(7'b0000001));
    end
    tick(in_t'(7'b0));
    chk("nack_replay_pulses", seen_rep, 300);
    chk("nack_no_done", seen_done, 0);
    chk("nack_replay_cnt_sat", replay_cnt_o, 255);

    // Asynchronous reset in the middle of REQ
    tick(in_t'(7'b1000000));
    tick(in_t'(7'b0000000));
    drive(in_t'(7'b0000100));
    #1;
    chk("pre_reset_mem_req_valid", mem_req_valid_o, 1);
    #2 rst = 1'b0;
    #1;
    chk("midreset_busy", busy_o, 0);
    chk("midreset_str_rdy", str_rdy_o, 0);
    chk("midreset_mem_req_valid", mem_req_valid_o, 0);
    chk("midreset_replay_cnt", replay_cnt_o, 0);
    chk("midreset_done", done_o, 0);
    chk("midreset_replay", replay_o, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    drive(in_t'(7'b0));
    @(posedge clk);
    #1;
    model_reset();
    seen_done = 0;
    tick(in_t'(7'b1000100));
    tick(in_t'(7'b0000100));
    tick(in_t'(7'b0000010));
    tick(in_t'(7'b0));
    chk("post_reset_done_count", seen_done, 1);

    // Watchdog behaviour on a translation that never hits
    tick(in_t'(7'b1010000));
`ifdef L1_DCACHE_SEQ_TIMEOUT_EN
    trans_cycles = 0;
    to_seen      = 0;
    for (int c = 0; c < 40 && !to_seen; c++) begin
      if (st_translation_req_o) trans_cycles++;
      if (timeout_o) to_seen = 1;
      if (!to_seen) tick(in_t'(7'b0));
    end
    chk("timeout_seen", to_seen, 1);
    chk("timeout_trans_cycles", trans_cycles, 16);
    chk("timeout_back_idle", busy_o, 0);
    tick(in_t'(7'b0));
`else
    trans_cycles = 0;
    to_seen      = 0;
    for (int c = 0; c < 1000; c++) begin
      if (st_translation_req_o) trans_cycles++;
      if (timeout_o) to_seen = 1;
      tick(in_t'(7'b0));
    end
    chk("no_timeout_trans_cycles", trans_cycles, 1000);
    chk("no_timeout_pulse", to_seen, 0);
    chk("no_timeout_still_busy", busy_o, 1);
    chk("no_timeout_still_trans", st_translation_req_o, 1);
    tick(in_t'(7'b0001000));
    tick(in_t'(7'b0000100));
    tick(in_t'(7'b0000010));
    tick(in_t'(7'b0));
`endif

    // Randomized traffic against the reference model
    for (int r = 0; r < 3000; r++) begin
      x.ld   = ($urandom_range(0, 9) < 2);
      x.st   = ($urandom_range(0, 9) < 2);
      x.trns = $urandom_range(0, 1);
      x.hit  = ($urandom_range(0, 9) < 3);
      x.rdy  = $urandom_range(0, 1);
      x.resp = ($urandom_range(0, 9) < 3);
      x.nack = ($urandom_range(0, 9) < 1);
      tick(x);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
